fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the pipelined MIPS core. It holds the PC, issues instruction reads to the icache, and loads the IF/ID latch that feeds the decode-stage control unit. It also handles hazard stalls, branch/jump redirects from EX, and the sticky halt state.

## Interface
Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- nRST  in  1  reset, synchronous, active-low.
- ihit  in  1  icache hit; iload valid this cycle.
- iload  in  32  instruction word from icache.
- iREN  out  1  icache read enable.
- iaddr  out  32  icache read address; equals the current PC.
- stall  in  1  hazard unit hold request for PC and IF/ID.
- redirect  in  1  taken branch or jump resolved in EX.
- redirect_pc  in  32  target PC for redirect.
- halt_in  in  1  HALT decoded in ID (the control unit's halt output).
- instr  out  32  IF/ID instruction to the control unit.
- npc  out  32  IF/ID PC+4 of instr.
- valid  out  1  IF/ID holds a real instruction; 0 means bubble.
- halted  out  1  sticky; fetch has stopped.
- fetch_cnt, miss_cyc  out  32 each  only when FETCH_PERF_EN is defined.

## Operation
- FSM has three states.
  - RUN: fetching; a request is outstanding every cycle.
  - WAIT: the previous cycle missed and the same address is re-presented.
  - HALTED: terminal state.
- FSM transitions:
  - RUN→WAIT on ~ihit; WAIT→RUN on ihit.
  - RUN/WAIT→HALTED on halt_in & ~stall & ~redirect.
  - HALTED exits only on reset.
- Outputs are combinational from state: iREN = (state != HALTED); iaddr = pc.
- Per-cycle priority, highest first:
  - redirect: pc ← redirect_pc; IF/ID ← bubble. Overrides stall and halt_in; a pending miss is abandoned.
  - halt_in & ~stall: IF/ID ← bubble; enter HALTED; pc unchanged.
  - stall: pc and IF/ID hold. Any ihit data is discarded and re-fetched.
  - ihit: IF/ID ← {instr=iload, npc=pc+4, valid=1}; pc ← pc+4.
  - ~ihit: IF/ID ← bubble; pc holds.
- A bubble is instr=32'h0 (sll $0,$0,0), npc=0, valid=0.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0. Low two bits of redirect_pc are forced to 0.
- In HALTED: IF/ID holds a bubble, iREN=0, halted=1; ihit, stall and redirect are ignored.

## Timing
- Reset (nRST low at an edge), values after that edge: pc=PC_INIT, state=RUN, instr=0, npc=0, valid=0, halted=0, counters=0. iREN=1 and iaddr=PC_INIT from the first cycle after reset.
- Reset mid-miss or mid-halt takes effect at the next edge, with no residual state.
- Hit latency: address at cycle N, instr valid at the IF/ID output from cycle N+1.
- Redirect asserted in cycle N: iaddr=redirect_pc in N+1; first target instruction valid in N+2 on a hit.
- Stall back-to-back for K cycles: IF/ID is frozen for exactly K cycles; no instruction is lost or duplicated.
- halt_in with stall: the halt is deferred until stall drops.

## Configuration
- FETCH_PERF_EN defined:
  - fetch_cnt increments on each IF/ID load with valid=1.
  - miss_cyc increments each cycle in WAIT.
  - Both saturate at 32'hFFFF_FFFF and freeze in HALTED.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- cpu_types_pkg adds fetch_state_t (RUN, WAIT, HALTED) and the constant NOP_INSTR = 32'h0. word_t is reused for all 32-bit fields.
- Sub-module if_id_reg: CLK, nRST, load, flush, instr/npc inputs, and instr/npc/valid outputs. Flush takes priority over load.
- fetch_unit contains the PC, the FSM, the priority logic and the optional counters.

## Test plan
- Reset and hit: PC_INIT=0, ihit=1, iload=32'h3402_0005 → cycle 1 instr=32'h3402_0005, npc=4, valid=1; iaddr steps 0,4,8.
- Miss: ihit=0 for 3 cycles at pc=8 → iaddr stays 8, valid=0 for 3 cycles; with FETCH_PERF_EN, miss_cyc=3.
- Stall: stall=1 for 2 cycles with IF/ID holding npc=8 → instr/npc frozen and pc=8 throughout; resumes at pc=8 afterwards.
- Redirect over stall: stall=1 and redirect=1 with redirect_pc=32'h0000_0103 → next iaddr=32'h100, valid=0.
- Halt: halt_in=1, stall=0 → halted=1 and iREN=0 next cycle; later redirect=1 ignored; nRST=0 restores pc=0, halted=0.
- Wrap: redirect to 32'hFFFF_FFFC followed by a hit → npc=0 and next iaddr=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared CPU types for the fetch stage: word type, fetch FSM states, NOP encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // sll $0,$0,0 -- the canonical bubble instruction
  localparam word_t NOP_INSTR = 32'h0000_0000;
  localparam word_t PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundles the icache, hazard/redirect and IF/ID signals of the fetch stage.
// Latency: n/a (wiring only).
// Backpressure: stall from the hazard unit, ihit from the icache. Optional FETCH_PERF_EN adds counters.
interface fetch_unit_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t iload;
  logic  iREN;
  word_t iaddr;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  logic  halt_in;
  word_t instr;
  word_t npc;
  logic  valid;
  logic  halted;
`ifdef FETCH_PERF_EN
  word_t fetch_cnt;
  word_t miss_cyc;
`endif

`ifdef FETCH_PERF_EN
  modport master (
    input  ihit, iload, stall, redirect, redirect_pc, halt_in,
    output iREN, iaddr, instr, npc, valid, halted, fetch_cnt, miss_cyc
  );
  modport slave (
    output ihit, iload, stall, redirect, redirect_pc, halt_in,
    input  iREN, iaddr, instr, npc, valid, halted, fetch_cnt, miss_cyc
  );
`else
  modport master (
    input  ihit, iload, stall, redirect, redirect_pc, halt_in,
    output iREN, iaddr, instr, npc, valid, halted
  );
  modport slave (
    output ihit, iload, stall, redirect, redirect_pc, halt_in,
    input  iREN, iaddr, instr, npc, valid, halted
  );
`endif

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline latch: captures instr/npc on load, writes a bubble on flush.
// Latency: 1 cycle from load/flush to outputs.
// Backpressure: neither load nor flush holds the current contents; flush beats load.
module if_id_reg
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  load,
  input  logic  flush,
  input  word_t instr_in,
  input  word_t npc_in,
  output word_t instr,
  output word_t npc,
  output logic  valid
);

  // Latch update: reset/flush give a bubble, load captures, otherwise hold.
  always_ff @(posedge CLK) begin
    if (!nRST || flush) begin
      instr <= NOP_INSTR;
      npc   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_in;
      npc   <= npc_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, the RUN/WAIT/HALTED FSM and the IF/ID load policy. Macro FETCH_PERF_EN adds counters.
// Latency: address in cycle N, instruction at IF/ID in N+1 on a hit; redirect target addressed in N+1.
// Backpressure: stall freezes PC and IF/ID (hit data dropped, refetched); a miss re-presents the PC and inserts bubbles.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
)(
  input logic          CLK,
  input logic          nRST,
  fetch_unit_if.master bus
);

  fetch_state_t state, state_nxt;
  word_t        pc, pc_nxt;
  word_t        pc_plus4;
  logic         ifid_load;
  logic         ifid_flush;

  assign pc_plus4 = pc + PC_STEP;  // 32-bit modulo wrap is intended

  // PC and FSM state register.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      pc    <= PC_INIT;
      state <= RUN;
    end else begin
      pc    <= pc_nxt;
      state <= state_nxt;
    end
  end

  // Priority: redirect > halt (unstalled) > stall > hit > miss; HALTED ignores everything.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    if (state == HALTED) begin
      ifid_flush = 1'b1;
    end else if (bus.redirect) begin
      pc_nxt     = {bus.redirect_pc[31:2], 2'b00};
      ifid_flush = 1'b1;
      state_nxt  = RUN;  // any outstanding miss is abandoned
    end else if (bus.halt_in && !bus.stall) begin
      ifid_flush = 1'b1;
      state_nxt  = HALTED;
    end else if (bus.stall) begin
      // Hold PC and IF/ID; still track the icache so miss cycles are accounted.
      state_nxt = bus.ihit ? RUN : WAIT;
    end else if (bus.ihit) begin
      ifid_load = 1'b1;
      pc_nxt    = pc_plus4;
      state_nxt = RUN;
    end else begin
      ifid_flush = 1'b1;
      state_nxt  = WAIT;
    end
  end

  assign bus.iREN   = (state != HALTED);
  assign bus.iaddr  = pc;
  assign bus.halted = (state == HALTED);

  if_id_reg u_if_id (
    .CLK      (CLK),
    .nRST     (nRST),
    .load     (ifid_load),
    .flush    (ifid_flush),
    .instr_in (bus.iload),
    .npc_in   (pc_plus4),
    .instr    (bus.instr),
    .npc      (bus.npc),
    .valid    (bus.valid)
  );

`ifdef FETCH_PERF_EN
  word_t fetch_cnt_q, miss_cyc_q;

  // Saturating performance counters; they stop moving once halted.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      fetch_cnt_q <= '0;
      miss_cyc_q  <= '0;
    end else if (state != HALTED) begin
      if (ifid_load && fetch_cnt_q != 32'hFFFF_FFFF)
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (state == WAIT && miss_cyc_q != 32'hFFFF_FFFF)
        miss_cyc_q <= miss_cyc_q + 32'd1;
    end
  end

  assign bus.fetch_cnt = fetch_cnt_q;
  assign bus.miss_cyc  = miss_cyc_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, hits, stall, miss, redirect, wrap, halt.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: stall and miss sequences driven explicitly.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic clk;
  logic nrst;
  int   n_cmp;
  int   n_err;

  fetch_unit_if bus();

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input word_t e_instr, input word_t e_npc,
                          input logic e_valid, input word_t e_iaddr);
    chk({tag, ".instr"}, bus.instr, e_instr);
    chk({tag, ".npc"},   bus.npc,   e_npc);
    chk({tag, ".valid"}, {31'b0, bus.valid}, {31'b0, e_valid});
    chk({tag, ".iaddr"}, bus.iaddr, e_iaddr);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    nrst            = 1'b0;
    bus.ihit        = 1'b0;
    bus.iload       = 32'h0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.halt_in     = 1'b0;

    // Reset state
    tick();
    chk_ifid("reset", 32'h0, 32'h0, 1'b0, 32'h0);
    chk("reset.iREN",   {31'b0, bus.iREN},   32'd1);
    chk("reset.halted", {31'b0, bus.halted}, 32'd0);

    // Two hits: iaddr steps 0 -> 4 -> 8
    nrst      = 1'b1;
    bus.ihit  = 1'b1;
    bus.iload = 32'h3402_0005;
    tick();
    chk_ifid("hit1", 32'h3402_0005, 32'd4, 1'b1, 32'd4);
    tick();
    chk_ifid("hit2", 32'h3402_0005, 32'd8, 1'b1, 32'd8);

    // Stall for 2 cycles: IF/ID and pc frozen, hit data discarded
    bus.stall = 1'b1;
    bus.iload = 32'hDEAD_BEEF;
    tick();
    chk_ifid("stall1", 32'h3402_0005, 32'd8, 1'b1, 32'd8);
    tick();
    chk_ifid("stall2", 32'h3402_0005, 32'd8, 1'b1, 32'd8);

    // Miss for 3 cycles at pc=8
    bus.stall = 1'b0;
    bus.ihit  = 1'b0;
    tick();
    chk_ifid("miss1", 32'h0, 32'h0, 1'b0, 32'd8);
    tick();
    chk_ifid("miss2", 32'h0, 32'h0, 1'b0, 32'd8);
    tick();
    chk_ifid("miss3", 32'h0, 32'h0, 1'b0, 32'd8);

    // Hit resumes at pc=8
    bus.ihit  = 1'b1;
    bus.iload = 32'hAAAA_0001;
    tick();
    chk_ifid("resume", 32'hAAAA_0001, 32'd12, 1'b1, 32'd12);
`ifdef FETCH_PERF_EN
    chk("perf.miss_cyc",  bus.miss_cyc,  32'd3);
    chk("perf.fetch_cnt", bus.fetch_cnt, 32'd3);
`endif

    // Redirect overrides stall; low bits of target cleared
    bus.stall       = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    tick();
    chk_ifid("redir", 32'h0, 32'h0, 1'b0, 32'h0000_0100);
    bus.stall    = 1'b0;
    bus.redirect = 1'b0;
    bus.iload    = 32'h1111_2222;
    tick();
    chk_ifid("redir_hit", 32'h1111_2222, 32'h0000_0104, 1'b1, 32'h0000_0104);

    // Wrap at the top of the address space
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    chk_ifid("wrap_redir", 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFC);
    bus.redirect = 1'b0;
    bus.iload    = 32'h2222_3333;
    tick();
    chk_ifid("wrap_hit", 32'h2222_3333, 32'h0, 1'b1, 32'h0);

    // Halt deferred by stall
    bus.halt_in = 1'b1;
    bus.stall   = 1'b1;
    bus.iload   = 32'h4444_5555;
    tick();
    chk_ifid("halt_stalled", 32'h2222_3333, 32'h0, 1'b1, 32'h0);
    chk("halt_stalled.halted", {31'b0, bus.halted}, 32'd0);

    // Halt takes effect once stall drops
    bus.stall = 1'b0;
    tick();
    chk_ifid("halt", 32'h0, 32'h0, 1'b0, 32'h0);
    chk("halt.halted", {31'b0, bus.halted}, 32'd1);
    chk("halt.iREN",   {31'b0, bus.iREN},   32'd0);

    // Redirect and hits ignored while halted
    bus.halt_in     = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    tick();
    bus.redirect = 1'b0;
    tick();
    chk_ifid("halted_ign", 32'h0, 32'h0, 1'b0, 32'h0);
    chk("halted_ign.halted", {31'b0, bus.halted}, 32'd1);
`ifdef FETCH_PERF_EN
    chk("perf.fetch_frozen", bus.fetch_cnt, 32'd5);
`endif

    // Reset leaves HALTED
    nrst = 1'b0;
    tick();
    chk_ifid("rst2", 32'h0, 32'h0, 1'b0, 32'h0);
    chk("rst2.halted", {31'b0, bus.halted}, 32'd0);
    chk("rst2.iREN",   {31'b0, bus.iREN},   32'd1);

    // Fetch restarts from PC_INIT
    nrst      = 1'b1;
    bus.iload = 32'h6666_7777;
    tick();
    chk_ifid("restart", 32'h6666_7777, 32'd4, 1'b1, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
